// File: rtl/temp_sense_sequencer_pkg.sv
// Shared definitions for the temperature scan sequencer: data widths and FSM state encoding.
package temp_sense_sequencer_pkg;

  localparam int ADC_W  = 16;
  localparam int BASE_W = 32;
  localparam int REF_W  = 8;
  localparam int TEMP_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CONV,
    ST_CALC,
    ST_OUT,
    ST_NEXT
  } seq_state_t;

endpackage

// File: rtl/TemperatureCalculator.sv
// Combinational temperature conversion shared by all sensor channels.
module TemperatureCalculator (
  input  logic [31:0] tc_base,
  input  logic [7:0]  tc_ref,
  input  logic [15:0] adc,
  output logic [31:0] tempc
);

  assign tempc = tc_base + 32'(adc) * 32'(tc_ref);

endmodule

// File: rtl/temp_sense_sequencer_tick.sv
// Scan-start divider: one tick every SAMPLE_DIV cycles while enabled, parked at zero otherwise.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/temp_sense_sequencer.sv
// Periodic multi-channel temperature scan: ADC request per channel, shared calculator,
// registered results on a valid/ready stream.
module temp_sense_sequencer
  import temp_sense_sequencer_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CHW         = 2,
  parameter int SAMPLE_DIV  = 1000,
  parameter int ADC_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [BASE_W-1:0] cfg_base,
  input  logic [REF_W-1:0]  cfg_ref,
  output logic              adc_start,
  output logic [CHW-1:0]    adc_ch,
  input  logic              adc_done,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              temp_valid,
  input  logic              temp_ready,
  output logic [CHW-1:0]    temp_ch,
  output logic [TEMP_W-1:0] temp_out,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_overrun,
  input  logic              clr_err
);

  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
  localparam logic [7:0]     TO_LAST = 8'(ADC_TIMEOUT - 1);
  localparam logic [CHW:0]   NCH_LIM = (CHW + 1)'(NCH);

  seq_state_t        state, state_nxt;
  logic [CHW-1:0]    ch;
  logic [7:0]        to_cnt;
  logic [ADC_W-1:0]  adc_lat;
  logic [TEMP_W-1:0] tempc;
  logic              tick;
  logic              conv_timeout;
  logic [BASE_W-1:0] cfg_base_q [NCH];
  logic [REF_W-1:0]  cfg_ref_q  [NCH];

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  TemperatureCalculator u_calc (
    .tc_base (cfg_base_q[ch]),
    .tc_ref  (cfg_ref_q[ch]),
    .adc     (adc_lat),
    .tempc   (tempc)
  );

  // A late adc_done on the final CONV cycle still wins over the timeout.
  assign conv_timeout = (state == ST_CONV) && !adc_done && (to_cnt == TO_LAST);
  assign adc_ch       = ch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    adc_start = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (tick) state_nxt = ST_START;
      end
      ST_START: begin
        adc_start = 1'b1;
        state_nxt = ST_CONV;
      end
      ST_CONV: begin
        if (adc_done)          state_nxt = ST_CALC;
        else if (conv_timeout) state_nxt = ST_NEXT;
      end
      ST_CALC: state_nxt = ST_OUT;
      ST_OUT:  if (temp_ready) state_nxt = ST_NEXT;
      ST_NEXT: state_nxt = (ch == LAST_CH) ? ST_IDLE : ST_START;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch      <= '0;
      to_cnt  <= '0;
      adc_lat <= '0;
    end else begin
      case (state)
        ST_IDLE:  ch <= '0;
        ST_START: to_cnt <= '0;
        ST_CONV: begin
          if (adc_done) adc_lat <= adc_data;
          else          to_cnt  <= to_cnt + 8'd1;
        end
        ST_NEXT:  ch <= (ch == LAST_CH) ? '0 : ch + CHW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp_valid <= 1'b0;
      temp_out   <= '0;
      temp_ch    <= '0;
    end else if (state == ST_CALC) begin
      temp_valid <= 1'b1;
      temp_out   <= tempc;
      temp_ch    <= ch;
    end else if (state == ST_OUT && temp_ready) begin
      temp_valid <= 1'b0;
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (conv_timeout) err_timeout <= 1'b1;
      else if (clr_err) err_timeout <= 1'b0;
      if (tick && state != ST_IDLE) err_overrun <= 1'b1;
      else if (clr_err)             err_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cfg_base_q[i] <= '0;
        cfg_ref_q[i]  <= '0;
      end
    end else if (cfg_we && ({1'b0, cfg_ch} < NCH_LIM)) begin
      cfg_base_q[cfg_ch] <= cfg_base;
      cfg_ref_q[cfg_ch]  <= cfg_ref;
    end
  end

endmodule
